// File: rtl/seq_pkg.sv
// Shared definitions for the program sequencer: FSM state encoding,
// instruction field positions and field widths.
package seq_pkg;

    localparam int IW_DEF = 28;
    localparam int OP_W   = 4;
    localparam int REG_W  = 4;
    localparam int IMM_W  = 8;

    // Instruction word layout (bit positions)
    localparam int WE_BIT   = 27;
    localparam int WSRC_BIT = 26;
    localparam int MUXA_BIT = 25;
    localparam int MUXB_BIT = 24;
    localparam int OP_LSB   = 20;
    localparam int DEST_LSB = 16;
    localparam int A_LSB    = 12;
    localparam int B_LSB    = 8;
    localparam int IMM_LSB  = 0;

    typedef enum logic [2:0] {
        S_IDLE,
        S_FETCH,
        S_EXEC,
        S_SETTLE,
        S_HALTED
    } state_e;

    // Datapath controls held steady from the instruction register
    typedef struct packed {
        logic             wsrc;
        logic             mux_a;
        logic             mux_b;
        logic [OP_W-1:0]  op;
        logic [REG_W-1:0] dest;
        logic [REG_W-1:0] a;
        logic [REG_W-1:0] b;
        logic [IMM_W-1:0] imm;
    } ctrl_t;

endpackage

// File: rtl/program_sequencer_if.sv
// Program-memory and datapath-control bundle for the sequencer.
// master = sequencer side, slave = memory/datapath side.
interface program_sequencer_if
    import seq_pkg::*;
#(
    parameter int PC_W = 8,
    parameter int IW   = IW_DEF
);
    logic             start;
    logic             halt_in;
    logic [IW-1:0]    instr_data;
    logic [PC_W-1:0]  instr_addr;
    logic             writeEnable;
    logic             writeSourceSelect;
    logic             muxASelect;
    logic             muxBSelect;
    logic [OP_W-1:0]  aluOpCode;
    logic [REG_W-1:0] destAddress;
    logic [REG_W-1:0] aAddress;
    logic [REG_W-1:0] bAddress;
    logic [IMM_W-1:0] extInputData;
    logic             busy;
    logic             done;

    modport master (
        input  start, halt_in, instr_data,
        output instr_addr, writeEnable, writeSourceSelect, muxASelect, muxBSelect,
               aluOpCode, destAddress, aAddress, bAddress, extInputData, busy, done
    );

    modport slave (
        output start, halt_in, instr_data,
        input  instr_addr, writeEnable, writeSourceSelect, muxASelect, muxBSelect,
               aluOpCode, destAddress, aAddress, bAddress, extInputData, busy, done
    );

endinterface

// File: rtl/program_sequencer_decode.sv
// Combinational split of the instruction register into datapath controls.
// The write-enable bit is not decoded here; it feeds the one-cycle strobe
// flop in the sequencer directly.
module instr_decode
    import seq_pkg::*;
(
    input  logic [WE_BIT-1:0] ir,
    output ctrl_t             ctrl
);

    // Field extraction, fixed layout
    always_comb begin
        ctrl       = '0;
        ctrl.wsrc  = ir[WSRC_BIT];
        ctrl.mux_a = ir[MUXA_BIT];
        ctrl.mux_b = ir[MUXB_BIT];
        ctrl.op    = ir[OP_LSB +: OP_W];
        ctrl.dest  = ir[DEST_LSB +: REG_W];
        ctrl.a     = ir[A_LSB +: REG_W];
        ctrl.b     = ir[B_LSB +: REG_W];
        ctrl.imm   = ir[IMM_LSB +: IMM_W];
    end

endmodule

// File: rtl/program_sequencer.sv
// Program sequencer: FETCH/EXEC/SETTLE per instruction, pc wraps modulo
// 2^PC_W, halts on halt_in sampled in SETTLE, restarts from 0 on start.
// Optional macro SEQ_SINGLE_STEP_EN adds step/step_mode inputs; with
// step_mode=1 SETTLE waits for a step pulse before the next FETCH.
module program_sequencer
    import seq_pkg::*;
#(
    parameter int PC_W = 8,
    parameter int IW   = IW_DEF
)(
    input  logic                clk,
    input  logic                rst,
`ifdef SEQ_SINGLE_STEP_EN
    input  logic                step,
    input  logic                step_mode,
`endif
    program_sequencer_if.master bus
);

    state_e            state;
    logic [PC_W-1:0]   pc;
    logic [WE_BIT-1:0] ir;      // instruction register below the we bit
    logic              we_q;    // we bit of the instruction, live only in EXEC
    logic              busy_q;
    logic              done_q;
    logic              advance;
    ctrl_t             ctrl;

`ifdef SEQ_SINGLE_STEP_EN
    assign advance = !step_mode || step;
`else
    assign advance = 1'b1;
`endif

    instr_decode u_decode (
        .ir   (ir),
        .ctrl (ctrl)
    );

    // Sequencer FSM with pc, IR and registered strobes; reset aborts at once
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state  <= S_IDLE;
            pc     <= '0;
            ir     <= '0;
            we_q   <= 1'b0;
            busy_q <= 1'b0;
            done_q <= 1'b0;
        end else begin
            case (state)
                S_IDLE, S_HALTED: begin
                    if (bus.start) begin
                        pc     <= '0;
                        state  <= S_FETCH;
                        busy_q <= 1'b1;
                        done_q <= 1'b0;
                    end
                end
                S_FETCH: begin
                    ir    <= bus.instr_data[WE_BIT-1:0];
                    we_q  <= bus.instr_data[WE_BIT];
                    state <= S_EXEC;
                end
                S_EXEC: begin
                    we_q  <= 1'b0;
                    state <= S_SETTLE;
                end
                S_SETTLE: begin
                    if (bus.halt_in) begin
                        state  <= S_HALTED;
                        busy_q <= 1'b0;
                        done_q <= 1'b1;
                    end else if (advance) begin
                        pc    <= pc + 1'b1;
                        state <= S_FETCH;
                    end
                end
                default: state <= S_IDLE;
            endcase
        end
    end

    assign bus.instr_addr        = pc;
    assign bus.writeEnable       = we_q;
    assign bus.writeSourceSelect = ctrl.wsrc;
    assign bus.muxASelect        = ctrl.mux_a;
    assign bus.muxBSelect        = ctrl.mux_b;
    assign bus.aluOpCode         = ctrl.op;
    assign bus.destAddress       = ctrl.dest;
    assign bus.aAddress          = ctrl.a;
    assign bus.bAddress          = ctrl.b;
    assign bus.extInputData      = ctrl.imm;
    assign bus.busy              = busy_q;
    assign bus.done              = done_q;

endmodule

// File: tb/tb_program_sequencer.sv
// Directed bench for program_sequencer: reset, a table-driven cycle trace of
// a short program with restarts, pc wrap, mid-EXEC reset and (when the
// macro SEQ_SINGLE_STEP_EN is defined) single-step hold.
module tb_program_sequencer;

    logic clk = 1'b0;
    logic rst;
`ifdef SEQ_SINGLE_STEP_EN
    logic step;
    logic step_mode;
`endif

    program_sequencer_if #(.PC_W(8), .IW(28)) bus ();

    program_sequencer #(.PC_W(8), .IW(28)) dut (
        .clk       (clk),
        .rst       (rst),
`ifdef SEQ_SINGLE_STEP_EN
        .step      (step),
        .step_mode (step_mode),
`endif
        .bus       (bus)
    );

    logic [27:0] rom [256];
    int n_vec = 0;
    int n_err = 0;

    always #5 clk = ~clk;

    // Program memory: read clocked mid-cycle so the word addressed in FETCH
    // is stable at the FETCH exit edge.
    always @(negedge clk) bus.instr_data <= rom[bus.instr_addr];

    typedef struct {
        logic       st;
        logic       h;
        logic [7:0] addr;
        logic       we;
        logic       busy;
        logic       done;
        logic [3:0] dest;
        logic [7:0] imm;
    } vec_t;

    vec_t tbl [18];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        logic [7:0] wa [6];
        logic       ww [6];

        for (int i = 0; i < 256; i++) rom[i] = 28'h0;
        rom[0] = 28'hC03005A;   // we, wsrc, dest=3, imm=5A
        rom[1] = 28'h0F00000;   // op=F (halt instruction for the datapath)
        rom[2] = 28'hA170011;   // we, muxA, op=1, dest=7, imm=11

        //            st    h     addr   we    busy  done  dest   imm
        tbl[0]  = '{1'b1, 1'b0, 8'd0, 1'b0, 1'b1, 1'b0, 4'd0, 8'h00};
        tbl[1]  = '{1'b0, 1'b1, 8'd0, 1'b1, 1'b1, 1'b0, 4'd3, 8'h5A};
        tbl[2]  = '{1'b1, 1'b1, 8'd0, 1'b0, 1'b1, 1'b0, 4'd3, 8'h5A};
        tbl[3]  = '{1'b0, 1'b0, 8'd1, 1'b0, 1'b1, 1'b0, 4'd3, 8'h5A};
        tbl[4]  = '{1'b0, 1'b0, 8'd1, 1'b0, 1'b1, 1'b0, 4'd0, 8'h00};
        tbl[5]  = '{1'b1, 1'b0, 8'd1, 1'b0, 1'b1, 1'b0, 4'd0, 8'h00};
        tbl[6]  = '{1'b0, 1'b1, 8'd1, 1'b0, 1'b0, 1'b1, 4'd0, 8'h00};
        tbl[7]  = '{1'b0, 1'b0, 8'd1, 1'b0, 1'b0, 1'b1, 4'd0, 8'h00};
        tbl[8]  = '{1'b1, 1'b0, 8'd0, 1'b0, 1'b1, 1'b0, 4'd0, 8'h00};
        tbl[9]  = '{1'b0, 1'b0, 8'd0, 1'b1, 1'b1, 1'b0, 4'd3, 8'h5A};
        tbl[10] = '{1'b0, 1'b0, 8'd0, 1'b0, 1'b1, 1'b0, 4'd3, 8'h5A};
        tbl[11] = '{1'b0, 1'b0, 8'd1, 1'b0, 1'b1, 1'b0, 4'd3, 8'h5A};
        tbl[12] = '{1'b0, 1'b0, 8'd1, 1'b0, 1'b1, 1'b0, 4'd0, 8'h00};
        tbl[13] = '{1'b0, 1'b1, 8'd1, 1'b0, 1'b1, 1'b0, 4'd0, 8'h00};
        tbl[14] = '{1'b0, 1'b0, 8'd2, 1'b0, 1'b1, 1'b0, 4'd0, 8'h00};
        tbl[15] = '{1'b0, 1'b0, 8'd2, 1'b1, 1'b1, 1'b0, 4'd7, 8'h11};
        tbl[16] = '{1'b0, 1'b0, 8'd2, 1'b0, 1'b1, 1'b0, 4'd7, 8'h11};
        tbl[17] = '{1'b0, 1'b1, 8'd2, 1'b0, 1'b0, 1'b1, 4'd7, 8'h11};

        // Reset state
        rst = 1'b1;
        bus.start = 1'b0;
        bus.halt_in = 1'b0;
`ifdef SEQ_SINGLE_STEP_EN
        step = 1'b0;
        step_mode = 1'b0;
`endif
        repeat (2) tick();
        chk("rst addr", bus.instr_addr, 0);
        chk("rst we", bus.writeEnable, 0);
        chk("rst busy", bus.busy, 0);
        chk("rst done", bus.done, 0);
        chk("rst dest", bus.destAddress, 0);
        chk("rst imm", bus.extInputData, 0);
        chk("rst op", bus.aluOpCode, 0);
        rst = 1'b0;

        // Idle holds without start
        for (int i = 0; i < 3; i++) begin
            tick();
            chk($sformatf("idle%0d busy", i), bus.busy, 0);
            chk($sformatf("idle%0d addr", i), bus.instr_addr, 0);
        end

        // Main cycle trace
        for (int i = 0; i < 18; i++) begin
            bus.start = tbl[i].st;
            bus.halt_in = tbl[i].h;
            tick();
            chk($sformatf("v%0d addr", i), bus.instr_addr, tbl[i].addr);
            chk($sformatf("v%0d we", i), bus.writeEnable, tbl[i].we);
            chk($sformatf("v%0d busy", i), bus.busy, tbl[i].busy);
            chk($sformatf("v%0d done", i), bus.done, tbl[i].done);
            chk($sformatf("v%0d dest", i), bus.destAddress, tbl[i].dest);
            chk($sformatf("v%0d imm", i), bus.extInputData, tbl[i].imm);
            if (i == 1) chk("v1 wsrc", bus.writeSourceSelect, 1);
            if (i == 4) chk("v4 op", bus.aluOpCode, 4'hF);
            if (i == 15) chk("v15 muxA", bus.muxASelect, 1);
        end
        bus.start = 1'b0;
        bus.halt_in = 1'b0;

        // pc wrap 254 -> 255 -> 0
        rom[255] = 28'h8000000;
        bus.start = 1'b1;
        tick();
        bus.start = 1'b0;
        repeat (762) tick();
        chk("wrap f254 addr", bus.instr_addr, 254);
        wa = '{8'd254, 8'd254, 8'd255, 8'd255, 8'd255, 8'd0};
        ww = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0};
        for (int i = 0; i < 6; i++) begin
            tick();
            chk($sformatf("wrap%0d addr", i), bus.instr_addr, wa[i]);
            chk($sformatf("wrap%0d we", i), bus.writeEnable, ww[i]);
            chk($sformatf("wrap%0d busy", i), bus.busy, 1);
        end
        tick();
        bus.halt_in = 1'b1;
        tick();
        tick();
        bus.halt_in = 1'b0;
        chk("wrap halt done", bus.done, 1);
        chk("wrap halt addr", bus.instr_addr, 0);

        // Reset asserted during EXEC of instruction 1
        rom[1] = 28'h8000000;
        bus.start = 1'b1;
        tick();
        bus.start = 1'b0;
        repeat (4) tick();
        chk("rexec addr", bus.instr_addr, 1);
        chk("rexec we before", bus.writeEnable, 1);
        #2 rst = 1'b1;
        #1;
        chk("rexec we async", bus.writeEnable, 0);
        chk("rexec busy async", bus.busy, 0);
        #1 rst = 1'b0;
        for (int i = 0; i < 3; i++) begin
            tick();
            chk($sformatf("rexec%0d addr", i), bus.instr_addr, 0);
            chk($sformatf("rexec%0d we", i), bus.writeEnable, 0);
            chk($sformatf("rexec%0d busy", i), bus.busy, 0);
            chk($sformatf("rexec%0d done", i), bus.done, 0);
        end

`ifdef SEQ_SINGLE_STEP_EN
        // Single-step hold in SETTLE
        step_mode = 1'b1;
        bus.start = 1'b1;
        tick();
        bus.start = 1'b0;
        tick();
        tick();
        for (int i = 0; i < 10; i++) begin
            tick();
            chk($sformatf("hold%0d addr", i), bus.instr_addr, 0);
            chk($sformatf("hold%0d busy", i), bus.busy, 1);
            chk($sformatf("hold%0d we", i), bus.writeEnable, 0);
        end
        step = 1'b1;
        tick();
        step = 1'b0;
        chk("step fetch addr", bus.instr_addr, 1);
        tick();
        chk("step exec we", bus.writeEnable, 1);
        step_mode = 1'b0;
        tick();
        tick();
        chk("free run addr", bus.instr_addr, 2);
`endif

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
